// File: rtl/readcode_burst_responder.sv
// readcode_burst_responder: turns one icache readcode request into a single
// line-aligned Avalon-MM read burst and streams the dwords back one by one.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   readcode_do/_address        request level + code address (bits [1:0] ignored)
//   readcode_partial(_done)     returned dword + one-cycle strobe
//   readcode_done               pulses with the final dword
//   avm_*                       Avalon-MM burst read master
//
// Optional feature: define READCODE_TIMEOUT_EN to enable an idle-beat
// watchdog that pads a stalled burst with 32'hFFFF_FFFF dwords.
module readcode_burst_responder #(
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readcode_do,
  input  logic [31:0] readcode_address,
  output logic        readcode_done,
  output logic [31:0] readcode_partial,
  output logic        readcode_partial_done,
  output logic [29:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_burstcount,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  localparam logic [31:0] LINE_MASK = ~32'(BURST_LEN * 4 - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA,
    FLUSH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   line_addr;
  logic          busy;
  logic          accept;
  logic          beat;

  assign line_addr      = readcode_address & LINE_MASK;
  assign busy           = (state == ISSUE) || (state == DATA);
  assign accept         = (state == ISSUE) && !avm_waitrequest;
  // Beats are counted from the accept cycle onward; IDLE beats are dropped.
  assign beat           = busy && avm_readdatavalid;
  assign avm_burstcount = 4'(BURST_LEN);

`ifdef READCODE_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
  logic          expire;

  assign expire = busy && !accept && !beat &&
                  (wd == WW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      cnt                   <= '0;
      avm_read              <= 1'b0;
      avm_address           <= '0;
      readcode_done         <= 1'b0;
      readcode_partial_done <= 1'b0;
      readcode_partial      <= '0;
`ifdef READCODE_TIMEOUT_EN
      wd                    <= '0;
`endif
    end else begin
      readcode_done         <= 1'b0;
      readcode_partial_done <= 1'b0;

      unique case (state)
        IDLE: begin
          // A request still high during the done pulse is the old one.
          if (readcode_do && !readcode_done) begin
            avm_address <= 30'(line_addr >> 2);
            avm_read    <= 1'b1;
            cnt         <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
        end
        FLUSH: begin
          readcode_partial      <= 32'hFFFF_FFFF;
          readcode_partial_done <= 1'b1;
          cnt                   <= cnt + 1'b1;
          if (cnt == LAST) begin
            readcode_done <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (beat) begin
        readcode_partial      <= avm_readdata;
        readcode_partial_done <= 1'b1;
        cnt                   <= cnt + 1'b1;
        if (cnt == LAST) begin
          readcode_done <= 1'b1;
          state         <= IDLE;
        end
      end

`ifdef READCODE_TIMEOUT_EN
      if (!busy || accept || beat) wd <= '0;
      else                         wd <= wd + 1'b1;
      if (expire) begin
        avm_read <= 1'b0;
        state    <= FLUSH;
      end
`endif
    end
  end

endmodule

// File: tb/tb_readcode_burst_responder.sv
// Self-checking bench for readcode_burst_responder: table vectors,
// hand sequences for multi-cycle corners, and randomized bursts.
module tb_readcode_burst_responder;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        readcode_do;
  logic [31:0] readcode_address;
  logic        readcode_done;
  logic [31:0] readcode_partial;
  logic        readcode_partial_done;
  logic [29:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  always #5 clk = ~clk;

  readcode_burst_responder #(
    .BURST_LEN(BL),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .readcode_do(readcode_do),
    .readcode_address(readcode_address),
    .readcode_done(readcode_done),
    .readcode_partial(readcode_partial),
    .readcode_partial_done(readcode_partial_done),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        done;
    logic [31:0] data;
  } strobe_t;

  strobe_t obs[$];

  always @(negedge clk) begin
    if (readcode_partial_done)
      obs.push_back({readcode_done, readcode_partial});
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One full transaction; expected stream is simply d[] in order,
  // done flagged on the last dword only.
  task automatic run_burst(input logic [31:0] addr, input int nwait,
                           input bit acc, input logic [15:0] gap,
                           input int drop, input logic [29:0] exp_a);
    logic [31:0] d[BL];
    logic [29:0] a0;
    int b;
    int k;
    for (int i = 0; i < BL; i++) d[i] = $urandom();
    obs.delete();
    readcode_address = addr;
    readcode_do = 1'b1;
    k = 0;
    while (!avm_read && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_rise", avm_read, 1);
    chk("cmd_addr", avm_address, exp_a);
    chk("burstcount", avm_burstcount, BL);
    a0 = avm_address;
    for (int i = 0; i < nwait; i++) begin
      avm_waitrequest = 1'b1;
      @(negedge clk);
      chk("wait_held", {avm_read, avm_address}, {1'b1, a0});
    end
    avm_waitrequest = 1'b0;
    b = 0;
    if (acc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = d[0];
      b = 1;
    end
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    chk("cmd_drop", avm_read, 0);
    if (drop != 0 && b >= drop) readcode_do = 1'b0;
    while (b < BL) begin
      for (int g = 0; g < int'(gap[b*4 +: 4]); g++) @(negedge clk);
      avm_readdatavalid = 1'b1;
      avm_readdata = d[b];
      b++;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (drop != 0 && b >= drop) readcode_do = 1'b0;
    end
    k = 0;
    while (!readcode_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", readcode_done, 1);
    chk("done_latency", k, 0);
    #1;
    chk("n_strobes", obs.size(), BL);
    for (int i = 0; i < BL && i < obs.size(); i++) begin
      chk("strobe_data", obs[i].data, d[i]);
      chk("strobe_done", obs[i].done, (i == BL - 1));
    end
    chk("single_cmd", avm_read, 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          nwait;
    bit          acc;
    logic [15:0] gap;
    int          drop;
    logic [29:0] exp_a;
  } vec_t;

  vec_t vec[5];

  initial begin
    logic [31:0] ra;
    logic [15:0] rg;
    int k;

    vec[0] = '{32'h0001_2346, 0, 1'b0, 16'h0000, 0, 30'h0000_48D0};
    vec[1] = '{32'h0001_2346, 5, 1'b0, 16'h0000, 0, 30'h0000_48D0};
    vec[2] = '{32'h0000_000C, 0, 1'b0, 16'h1020, 0, 30'h0000_0000};
    vec[3] = '{32'hFFFF_FFFF, 2, 1'b1, 16'h0010, 0, 30'h3FFF_FFFC};
    vec[4] = '{32'h8000_0010, 1, 1'b0, 16'h0303, 0, 30'h2000_0004};

    reset = 1'b1;
    readcode_do = 1'b0;
    readcode_address = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {avm_read, avm_address, readcode_done,
                       readcode_partial_done, readcode_partial}, 0);
    chk("reset_bcount", avm_burstcount, BL);
    reset = 1'b0;

    foreach (vec[i]) begin
      run_burst(vec[i].addr, vec[i].nwait, vec[i].acc, vec[i].gap,
                vec[i].drop, vec[i].exp_a);
      readcode_do = 1'b0;
      @(negedge clk);
    end

    // Abort after beat 1, then back-to-back request held in done cycle.
    run_burst(32'h0000_0104, 0, 1'b0, 16'h0000, 1, 30'h0000_0040);
    readcode_address = 32'h0000_0208;
    readcode_do = 1'b1;
    @(negedge clk);
    chk("b2b_ignored", avm_read, 0);
    @(negedge clk);
    chk("b2b_accept", avm_read, 1);
    run_burst(32'h0000_0208, 1, 1'b0, 16'h0100, 0, 30'h0000_0080);
    readcode_do = 1'b0;
    @(negedge clk);

    // Reset in the middle of the data phase.
    readcode_address = 32'h0000_0040;
    readcode_do = 1'b1;
    @(negedge clk);
    @(negedge clk);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h1234_5678;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    chk("pre_rst_data", readcode_partial, 32'h1234_5678);
    #2 reset = 1'b1;
    #1;
    chk("rst_async", {avm_read, avm_address, readcode_done,
                      readcode_partial_done, readcode_partial}, 0);
    readcode_do = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    obs.delete();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("stray_no_strobe", obs.size(), 0);
    chk("stray_no_read", avm_read, 0);

    // Randomized bursts with stray idle beats between them.
    for (int it = 0; it < 25; it++) begin
      ra = $urandom();
      rg = 16'($urandom_range(0, 16'hFFFF)) & 16'h3333;
      run_burst(ra, $urandom_range(0, 4), 1'($urandom_range(0, 1)), rg,
                $urandom_range(0, BL), 30'((ra / (BL * 4)) * BL));
      readcode_do = 1'b0;
      obs.delete();
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        avm_readdatavalid = 1'b1;
        @(negedge clk);
      end
      avm_readdatavalid = 1'b0;
      @(negedge clk);
      #1;
      chk("idle_stray", obs.size(), 0);
    end

`ifdef READCODE_TIMEOUT_EN
    // Only two beats arrive; the watchdog pads the rest.
    obs.delete();
    readcode_address = 32'h0000_0300;
    readcode_do = 1'b1;
    @(negedge clk);
    @(negedge clk);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hAAAA_0001;
    @(negedge clk);
    avm_readdata = 32'hAAAA_0002;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    k = 0;
    while (!readcode_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("to_done", readcode_done, 1);
    #1;
    chk("to_count", obs.size(), BL);
    if (obs.size() == BL) begin
      chk("to_d0", obs[0].data, 32'hAAAA_0001);
      chk("to_d1", obs[1].data, 32'hAAAA_0002);
      chk("to_pad2", {obs[2].done, obs[2].data}, {1'b0, 32'hFFFF_FFFF});
      chk("to_pad3", {obs[3].done, obs[3].data}, {1'b1, 32'hFFFF_FFFF});
    end
    readcode_do = 1'b0;
    avm_readdatavalid = 1'b1;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("to_late_drop", obs.size(), BL);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
